hetszegmens_scanner: RTL and testbench
======================================

# hetszegmens_scanner

Time-multiplexed driver for a DIGITS-digit common-enable seven-segment display. It accepts a packed hex value through a valid/ready load port and double-buffers it so updates land only on frame boundaries. It scans the digits one at a time, presenting each 4-bit nibble to the downstream bin2hetszegmens decoder together with a one-hot digit enable. A blanking interval between digits prevents ghosting, and optional leading-zero blanking is supported.

## Interface
- DIGITS, 4, number of digits; legal 1..8
- SHOW_CYCLES, 50000, clock cycles a digit is enabled per slot; ≥1
- BLANK_CYCLES, 500, clock cycles all digits are off before each slot; ≥1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  new value offered
- load_data  in  4*DIGITS  packed nibbles; nibble i = bits [4i+3:4i], nibble 0 = rightmost digit
- load_dp  in  DIGITS  decimal-point request per digit, same indexing
- load_ready  out  1  shadow register free; transfer on load_valid & load_ready
- lz_blank_en  in  1  enable leading-zero blanking (sampled live, not buffered)
- digit_bin  out  4  nibble of the active digit, to decoder input
- digit_en  out  DIGITS  one-hot active-high digit enable; all-zero while blanked
- dp_out  out  1  decimal point for the active digit; 0 whenever digit_en is 0

## Operation
- Registers: shadow (data+dp), pending flag, display (data+dp), slot counter, digit index, state.
- FSM states:
  - BLANK: digit_en = 0; lasts BLANK_CYCLES cycles; then → SHOW.
  - SHOW: digit_en = one-hot(index) unless the digit is LZ-suppressed; lasts SHOW_CYCLES cycles; then → BLANK with index+1, wrapping DIGITS-1 → 0.
- Frame boundary: the last SHOW cycle of index DIGITS-1. If pending was already 1 before that cycle, display ← shadow and pending ← 0 on that edge.
- Load: load_ready = ~pending. An accepted transfer sets pending and captures shadow. A load accepted on the boundary cycle itself (pending was 0) waits for the next boundary.
- Leading-zero suppression: digit i (i ≥ 1) is suppressed when lz_blank_en = 1 and display nibbles DIGITS-1 down to i are all zero. Digit 0 is never suppressed. A suppressed digit keeps its slot timing with digit_en = 0 and dp_out = 0.
- digit_bin always carries display nibble[index], including during BLANK, so the decoder settles before enable.
- Counter width is $clog2(max(SHOW_CYCLES, BLANK_CYCLES)+1). No arithmetic on data.

## Timing
- Reset values: state = BLANK, index = 0, counter = 0, digit_en = 0, digit_bin = 0, dp_out = 0, pending = 0, load_ready = 1, display = 0, shadow = 0.
- First digit_en (bit 0) rises BLANK_CYCLES cycles after rst deasserts.
- All outputs are registered, with one-cycle latency from state/index change.
- Slot period = BLANK_CYCLES + SHOW_CYCLES; frame period = DIGITS × slot period.
- load_ready falls the cycle after acceptance. It rises the cycle after the frame boundary that consumes the shadow.
- Worst-case load-to-display latency is just under 2 frames.
- Reset mid-frame or mid-handshake returns every register to its reset value; any pending load is discarded.
- digit_en never has more than one bit set. It is zero for at least BLANK_CYCLES between any two distinct enables.

## Structure
- Shared package hetszegmens_pkg: FSM state enum (BLANK, SHOW), a function computing the LZ suppression mask from packed data and DIGITS.
- Sub-module hetszegmens_lz_mask: combinational, with display data and lz_blank_en in, DIGITS-bit suppress mask out.
- bin2hetszegmens is instantiated by the parent, not inside this block.

## Test plan
Use DIGITS=4, SHOW=4, BLANK=2, giving a 24-cycle frame.
- Reset, then idle: digit_en = 0000 for 2 cycles, then 0001 for 4 cycles; cycle sequence 0000,0001,0000,0010,0000,0100,0000,1000 repeats; digit_bin = 0; load_ready = 1.
- Load 16'h12AF, dp = 4'b0100 mid-frame:
  - load_ready drops next cycle.
  - digit_bin during the slots after the next boundary reads F, A, 2, 1.
  - dp_out = 1 only while digit_en = 0100.
  - load_ready rises the cycle after the boundary.
- Load 16'h0007, lz_blank_en = 1: digit_en asserts only as 0001 with digit_bin = 7; slots 1–3 stay 0000 with correct timing. lz_blank_en = 0 shows 0,0,0 as well.
- Back-to-back loads:
  - Load A accepted, then load_valid held with B; B is not accepted until load_ready returns.
  - Display shows A for a full frame before B.
  - A load accepted on the boundary cycle appears one frame later.
- Assert rst during SHOW of digit 2 with a load pending: next cycle digit_en = 0000, load_ready = 1, display = 0; the pending value never appears.
- Continuous run of 10 frames: assertion that digit_en is one-hot-or-zero and that dp_out implies digit_en ≠ 0.

Source files
------------

// File: rtl/hetszegmens_pkg.sv
// rtl/hetszegmens_pkg.sv - shared types and leading-zero helper for the seven-segment scanner
package hetszegmens_pkg;

    localparam int MAX_DIGITS = 8;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // True when digit idx is a leading zero: every nibble from the top digit down to idx is zero.
    // Digit 0 is never reported, so an all-zero value still shows a single 0.
    function automatic logic lz_suppressed(input logic [4*MAX_DIGITS-1:0] data,
                                           input int digits, input int idx);
        logic all_zero;
        all_zero = (idx >= 1);
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k >= idx && k < digits && data[4*k +: 4] != 4'h0)
                all_zero = 1'b0;
        end
        return all_zero;
    endfunction

endpackage

// File: rtl/hetszegmens_scanner_if.sv
// rtl/hetszegmens_scanner_if.sv - valid/ready load port carrying packed nibbles and decimal points
interface hetszegmens_scanner_if #(parameter int DIGITS = 4);

    logic                  load_valid;
    logic [4*DIGITS-1:0]   load_data;
    logic [DIGITS-1:0]     load_dp;
    logic                  load_ready;

    modport master (output load_valid, load_data, load_dp, input load_ready);
    modport slave  (input load_valid, load_data, load_dp, output load_ready);

endinterface

// File: rtl/hetszegmens_lz_mask.sv
// rtl/hetszegmens_lz_mask.sv - combinational per-digit leading-zero suppress mask
module hetszegmens_lz_mask
    import hetszegmens_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] data_i,
    input  logic                lz_blank_en_i,
    output logic [DIGITS-1:0]   suppress_o
);

    logic [4*MAX_DIGITS-1:0] data_pad;

    always_comb begin
        data_pad                = '0;
        data_pad[4*DIGITS-1:0]  = data_i;
        suppress_o              = '0;
        for (int i = 0; i < DIGITS; i++)
            suppress_o[i] = lz_blank_en_i & lz_suppressed(data_pad, DIGITS, i);
    end

endmodule

// File: rtl/hetszegmens_scanner.sv
// rtl/hetszegmens_scanner.sv - double-buffered, blanked, time-multiplexed seven-segment digit scanner
module hetszegmens_scanner
    import hetszegmens_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst,
    hetszegmens_scanner_if.slave ld,
    input  logic                lz_blank_en,
    output logic [3:0]          digit_bin,
    output logic [DIGITS-1:0]   digit_en,
    output logic                dp_out
);

    localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    scan_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]  shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]  disp_data_q, disp_data_d;
    logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
    logic                 pending_q, pending_d;
    logic [3:0]           digit_bin_q, digit_bin_d;
    logic [DIGITS-1:0]    digit_en_q, digit_en_d;
    logic                 dp_q, dp_d;
    logic [DIGITS-1:0]    suppress;
    logic                 accept;
    logic                 boundary;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                end
            end
        endcase
    end

    // Shadow only moves to the display on the last SHOW cycle of the top digit,
    // so a frame is never torn; a load accepted on that same cycle waits a full frame.
    always_comb begin
        accept        = ld.load_valid & ~pending_q;
        boundary      = (state_q == ST_SHOW) && (idx_q == IDX_LAST) && (cnt_q == SHOW_LAST);
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        disp_data_d   = disp_data_q;
        disp_dp_d     = disp_dp_q;
        pending_d     = pending_q;
        if (boundary && pending_q) begin
            disp_data_d = shadow_data_q;
            disp_dp_d   = shadow_dp_q;
            pending_d   = 1'b0;
        end
        if (accept) begin
            shadow_data_d = ld.load_data;
            shadow_dp_d   = ld.load_dp;
            pending_d     = 1'b1;
        end
    end

    hetszegmens_lz_mask #(.DIGITS(DIGITS)) u_lz_mask (
        .data_i        (disp_data_d),
        .lz_blank_en_i (lz_blank_en),
        .suppress_o    (suppress)
    );

    // Outputs are computed from the next state so the registered pins line up with state_q.
    always_comb begin
        digit_en_d  = '0;
        digit_bin_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                digit_bin_d = disp_data_d[4*i +: 4];
                if (state_d == ST_SHOW && !suppress[i])
                    digit_en_d[i] = 1'b1;
            end
        end
        dp_d = |(digit_en_d & disp_dp_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            pending_q     <= 1'b0;
            digit_bin_q   <= '0;
            digit_en_q    <= '0;
            dp_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            pending_q     <= pending_d;
            digit_bin_q   <= digit_bin_d;
            digit_en_q    <= digit_en_d;
            dp_q          <= dp_d;
        end
    end

    assign ld.load_ready = ~pending_q;
    assign digit_bin     = digit_bin_q;
    assign digit_en      = digit_en_q;
    assign dp_out        = dp_q;

endmodule

// File: tb/tb_hetszegmens_scanner.sv
// tb/tb_hetszegmens_scanner.sv - randomized bench against a time-arithmetic reference model
module tb_hetszegmens_scanner;

    localparam int D     = 4;
    localparam int S     = 4;
    localparam int B     = 2;
    localparam int P     = B + S;
    localparam int FRAME = D * P;

    logic         clk = 1'b0;
    logic         rst;
    logic         lz_blank_en;
    logic [3:0]   digit_bin;
    logic [D-1:0] digit_en;
    logic         dp_out;

    hetszegmens_scanner_if #(.DIGITS(D)) lif ();

    hetszegmens_scanner #(.DIGITS(D), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld          (lif),
        .lz_blank_en (lz_blank_en),
        .digit_bin   (digit_bin),
        .digit_en    (digit_en),
        .dp_out      (dp_out)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          m_t;
    logic [15:0] m_disp, m_sh;
    logic [3:0]  m_dp, m_shdp;
    logic        m_pend, m_lz;
    logic [15:0] q_data[$];
    logic [3:0]  q_dp[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @t=%0d: got %0h, expected %0h", tag, m_t, got, exp);
        end
    endtask

    // Time since reset determines slot and phase; display/shadow follow the frame-boundary rule.
    task automatic model_edge();
        logic        acc;
        logic        bnd;
        logic [15:0] drop_d;
        logic [3:0]  drop_p;
        m_lz = lz_blank_en;
        if (rst) begin
            m_t = 0; m_disp = '0; m_dp = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0;
        end else begin
            acc = lif.load_valid && !m_pend;
            bnd = ((m_t + 1) % FRAME) == 0;
            if (bnd && m_pend) begin
                m_disp = m_sh; m_dp = m_shdp; m_pend = 1'b0;
            end
            if (acc) begin
                m_sh = lif.load_data; m_shdp = lif.load_dp; m_pend = 1'b1;
                drop_d = q_data.pop_front();
                drop_p = q_dp.pop_front();
            end
            m_t++;
        end
    endtask

    task automatic compare();
        int          slot;
        int          off;
        logic [15:0] upper;
        logic [3:0]  en_e;
        logic        dp_e;
        slot  = (m_t / P) % D;
        off   = m_t % P;
        upper = m_disp >> (4 * slot);
        en_e  = (off >= B && !(m_lz && slot >= 1 && upper == 16'h0)) ? 4'(1 << slot) : 4'h0;
        dp_e  = (en_e != 4'h0) && m_dp[slot];
        check_eq("digit_en", 32'(digit_en), 32'(en_e));
        check_eq("digit_bin", 32'(digit_bin), 32'(upper[3:0]));
        check_eq("dp_out", 32'(dp_out), 32'(dp_e));
        check_eq("load_ready", 32'(lif.load_ready), 32'(!m_pend));
        check_eq("en_onehot0", 32'($onehot0(digit_en)), 32'd1);
        check_eq("dp_needs_en", 32'(dp_out && digit_en == '0), 32'd0);
    endtask

    task automatic step();
        if (q_data.size() != 0) begin
            lif.load_valid = 1'b1;
            lif.load_data  = q_data[0];
            lif.load_dp    = q_dp[0];
        end else begin
            lif.load_valid = 1'b0;
            lif.load_data  = 16'($urandom);
            lif.load_dp    = 4'($urandom);
        end
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int phase);
        for (int i = 0; i < FRAME && (m_t % FRAME) != phase; i++) step();
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] p);
        q_data.push_back(d);
        q_dp.push_back(p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        lz_blank_en    = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        lif.load_dp    = '0;
        m_t = 0; m_disp = '0; m_dp = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0; m_lz = 1'b0;

        do_reset();
        run(FRAME + 2);

        run_until(5);
        push(16'h12AF, 4'b0100);
        run(2 * FRAME);

        lz_blank_en = 1'b1;
        push(16'h0007, 4'b0000);
        run(2 * FRAME);
        lz_blank_en = 1'b0;
        run(FRAME);

        push(16'hA5C3, 4'b1001);
        push(16'h3E0B, 4'b0010);
        run(3 * FRAME);

        run_until(FRAME - 1);
        push(16'h5A3C, 4'b1000);
        run(2 * FRAME + 2);

        run_until(0);
        push(16'hBEEF, 4'b1111);
        run_until(2 * P + B + 1);
        do_reset();
        run(2 * FRAME);

        for (int i = 0; i < 12 * FRAME; i++) begin
            if (q_data.size() == 0 && $urandom_range(0, 7) == 0)
                push(16'($urandom), 4'($urandom));
            if ($urandom_range(0, 15) == 0)
                lz_blank_en = ~lz_blank_en;
            if ($urandom_range(0, 3) == 0)
                push(16'($urandom_range(0, 255)), 4'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
